// File: rtl/sccb_slave_regfile.sv
// sccb_slave_regfile: SCCB/I2C target with a 256x8 register file.
// Ports: iCLK/iRST_N, I2C_SCLK/I2C_SDAT bus, REG_* local read, WR_* write tap, BUSY.
module sccb_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h21,
  parameter logic [7:0] PID_VAL    = 8'h77,
  parameter logic [7:0] VER_VAL    = 8'h21
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  input  logic [7:0] REG_RADDR,
  output logic [7:0] REG_RDATA,
  output logic       WR_STROBE,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, SUB, SUB_ACK,
    WDATA, WDATA_ACK, RDATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t      state, stateNxt;
  logic [2:0]  sclS, sdaS;
  logic [3:0]  cnt, cntNxt;
  logic [7:0]  shReg, shNxt;
  logic [7:0]  ptr, ptrNxt;
  logic        sdaLow, sdaLowNxt;
  logic        busyNxt;
  logic        wrEn;
  logic [7:0]  memRd;
  logic [7:0]  mem [256];

  logic sclHi, sclRise, sclFall, sdaIn;
  logic startDet, stopDet;

  // open-drain: only ever pull low
  assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sclS <= 3'b111;
      sdaS <= 3'b111;
    end else begin
      sclS <= {sclS[1:0], I2C_SCLK};
      sdaS <= {sdaS[1:0], I2C_SDAT};
    end
  end

  assign sclHi    = sclS[1] & sclS[2];
  assign sclRise  = sclS[1] & ~sclS[2];
  assign sclFall  = ~sclS[1] & sclS[2];
  assign sdaIn    = sdaS[1];
  assign startDet = sclHi & ~sdaS[1] & sdaS[2];
  assign stopDet  = sclHi & sdaS[1] & ~sdaS[2];
  assign memRd    = mem[ptr];

  always_comb begin
    stateNxt  = state;
    cntNxt    = cnt;
    shNxt     = shReg;
    ptrNxt    = ptr;
    sdaLowNxt = sdaLow;
    busyNxt   = BUSY;
    wrEn      = 1'b0;
    if (startDet) begin
      stateNxt  = DEV;
      cntNxt    = '0;
      sdaLowNxt = 1'b0;
      busyNxt   = 1'b1;
    end else if (stopDet) begin
      stateNxt  = IDLE;
      sdaLowNxt = 1'b0;
      busyNxt   = 1'b0;
    end else if (sclRise) begin
      // RD_ACK shifts too: shReg[0] then holds the master ack
      if (state inside {DEV, SUB, WDATA, RD_ACK}) begin
        shNxt  = {shReg[6:0], sdaIn};
        cntNxt = cnt + 4'd1;
      end
    end else if (sclFall) begin
      unique case (state)
        DEV: begin
          if (cnt == 4'd8) begin
            if (shReg[7:1] == SLAVE_ADDR) begin
              sdaLowNxt = 1'b1;
              stateNxt  = DEV_ACK;
            end else begin
              stateNxt  = WAIT_STOP;
            end
          end
        end
        DEV_ACK: begin
          cntNxt    = '0;
          sdaLowNxt = 1'b0;
          if (shReg[0]) begin
            shNxt     = memRd;
            sdaLowNxt = ~memRd[7];
            stateNxt  = RDATA;
          end else begin
            stateNxt  = SUB;
          end
        end
        SUB: begin
          if (cnt == 4'd8) begin
            ptrNxt    = shReg;
            sdaLowNxt = 1'b1;
            stateNxt  = SUB_ACK;
          end
        end
        SUB_ACK, WDATA_ACK: begin
          sdaLowNxt = 1'b0;
          cntNxt    = '0;
          stateNxt  = WDATA;
        end
        WDATA: begin
          if (cnt == 4'd8) begin
            wrEn      = 1'b1;
            ptrNxt    = ptr + 8'd1;
            sdaLowNxt = 1'b1;
            stateNxt  = WDATA_ACK;
          end
        end
        RDATA: begin
          if (cnt == 4'd7) begin
            sdaLowNxt = 1'b0;
            ptrNxt    = ptr + 8'd1;
            cntNxt    = '0;
            stateNxt  = RD_ACK;
          end else begin
            shNxt     = {shReg[6:0], 1'b0};
            sdaLowNxt = ~shReg[6];
            cntNxt    = cnt + 4'd1;
          end
        end
        RD_ACK: begin
          if (!shReg[0]) begin
            shNxt     = memRd;
            sdaLowNxt = ~memRd[7];
            cntNxt    = '0;
            stateNxt  = RDATA;
          end else begin
            sdaLowNxt = 1'b0;
            stateNxt  = WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      shReg     <= '0;
      ptr       <= '0;
      sdaLow    <= 1'b0;
      BUSY      <= 1'b0;
      WR_STROBE <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      REG_RDATA <= '0;
      for (int i = 0; i < 256; i++) begin
        mem[i] <= (i == 10) ? PID_VAL :
                  (i == 11) ? VER_VAL : 8'h00;
      end
    end else begin
      state     <= stateNxt;
      cnt       <= cntNxt;
      shReg     <= shNxt;
      ptr       <= ptrNxt;
      sdaLow    <= sdaLowNxt;
      BUSY      <= busyNxt;
      WR_STROBE <= wrEn;
      // old contents on a same-cycle local read of the written address
      REG_RDATA <= mem[REG_RADDR];
      if (wrEn) begin
        mem[ptr] <= shReg;
        WR_ADDR  <= ptr;
        WR_DATA  <= shReg;
      end
    end
  end

endmodule
